branch_resolve_unit: RTL

- Parametrised branch-condition resolver for the pipelined MIPS core. Generalises the single-op bltz taken gate to six conditional branch types.
- Computes taken/target in ID and registers them into one output stage (ID/EX boundary), with stall and flush control.
- Keeps saturating branch/taken event counters for performance readout.

---
 rtl/branch_resolve_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// Branch condition resolver for the ID stage of the pipelined MIPS core.
// Resolves six conditional branch types, computes the branch target, and
// registers the result into the ID/EX boundary with stall and flush control.
// Saturating branch/taken event counters are kept for performance readout.
module branch_resolve_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             valid_in,
    input  logic [2:0]       br_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [WIDTH-1:0] pc4,
    input  logic [15:0]      imm16,
    output logic             valid_out,
    output logic             is_branch,
    output logic             taken,
    output logic [WIDTH-1:0] target,
    output logic             illegal,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_BEQ  = 3'd1,
        OP_BNE  = 3'd2,
        OP_BLEZ = 3'd3,
        OP_BGTZ = 3'd4,
        OP_BLTZ = 3'd5,
        OP_BGEZ = 3'd6,
        OP_ILL  = 3'd7
    } br_op_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    br_op_e           op;
    logic             cond;
    logic             op_is_branch;
    logic             rs_neg;
    logic             rs_zero;
    logic [WIDTH-1:0] offset;
    logic [WIDTH-1:0] target_calc;

    logic             valid_q,   valid_d;
    logic             is_br_q,   is_br_d;
    logic             taken_q,   taken_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] target_q,  target_d;
    logic [CNT_W-1:0] br_cnt_q,  br_cnt_d;
    logic [CNT_W-1:0] tk_cnt_q,  tk_cnt_d;

    assign op      = br_op_e'(br_op);
    assign rs_neg  = rs_val[WIDTH-1];
    assign rs_zero = (rs_val == '0);

    // Word offset: sign-extend {imm16, 00} to WIDTH; the add wraps naturally.
    assign offset      = WIDTH'($signed({imm16, 2'b00}));
    assign target_calc = pc4 + offset;

    // Branch condition decode; rt only matters for beq/bne.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cond         = 1'b0;
        op_is_branch = 1'b1;
        case (op)
            OP_BEQ:  cond = (rs_val == rt_val);
            OP_BNE:  cond = (rs_val != rt_val);
            OP_BLEZ: cond = rs_neg | rs_zero;
            OP_BGTZ: cond = !rs_neg & !rs_zero;
            OP_BLTZ: cond = rs_neg;
            OP_BGEZ: cond = !rs_neg;
            default: op_is_branch = 1'b0;
        endcase
    end

    // Next-state for the output stage and counters: flush > stall > capture/bubble.
    always_comb begin
        valid_d   = valid_q;
        is_br_d   = is_br_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        target_d  = target_q;
        br_cnt_d  = br_cnt_q;
        tk_cnt_d  = tk_cnt_q;
        if (flush) begin
            valid_d   = 1'b0;
            is_br_d   = 1'b0;
            taken_d   = 1'b0;
            illegal_d = 1'b0;
        end else if (!stall) begin
            if (valid_in) begin
                valid_d   = 1'b1;
                is_br_d   = op_is_branch;
                taken_d   = cond;
                illegal_d = (op == OP_ILL);
                target_d  = target_calc;
                if (op_is_branch) begin
                    if (br_cnt_q != CNT_MAX) br_cnt_d = br_cnt_q + CNT_W'(1);
                    if (cond && tk_cnt_q != CNT_MAX) tk_cnt_d = tk_cnt_q + CNT_W'(1);
                end
            end else begin
                valid_d   = 1'b0;
                is_br_d   = 1'b0;
                taken_d   = 1'b0;
                illegal_d = 1'b0;
            end
        end
    end

    // Output stage and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so all registers update together from pre-edge values.
        if (reset) begin
            valid_q   <= 1'b0;
            is_br_q   <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            target_q  <= '0;
            br_cnt_q  <= '0;
            tk_cnt_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            is_br_q   <= is_br_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
            target_q  <= target_d;
            br_cnt_q  <= br_cnt_d;
            tk_cnt_q  <= tk_cnt_d;
        end
    end

    assign valid_out    = valid_q;
    assign is_branch    = is_br_q;
    assign taken        = taken_q;
    assign illegal      = illegal_q;
    assign target       = target_q;
    assign branch_count = br_cnt_q;
    assign taken_count  = tk_cnt_q;

endmodule
